// File: rtl/input_port_buffer.sv
// Receive-side link buffer: grants an upstream request only when a whole packet fits,
// stores wormhole flits in a circular FIFO and presents them show-ahead to route compute.
module input_port_buffer #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned MAX_PKT_FLITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_upstream_req,
  output logic                     o_upstream_ack,
  input  logic                     i_flit_valid,
  input  logic [1:0]               i_flit_type,
  input  logic [DATA_W-1:0]        i_flit_data,
  output logic                     o_flit_valid,
  input  logic                     i_flit_ready,
  output logic [1:0]               o_flit_type,
  output logic [DATA_W-1:0]        o_flit_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = $clog2(MAX_PKT_FLITS + 1);

  localparam logic [1:0] FT_HEAD      = 2'b00;
  localparam logic [1:0] FT_TAIL      = 2'b10;
  localparam logic [1:0] FT_HEAD_TAIL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RECV
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     len_q, len_d;
  logic              err_d;

  logic [1:0]        type_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic space_ok;
  logic is_head;
  logic is_tail;
  logic last_slot;

  // Pointer-derived FIFO status; the wrap bit separates full from empty
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop      = !empty && i_flit_ready;
  assign push     = (state_q == ST_RECV) && i_flit_valid && (!full || pop);

  // Reservation uses the registered count only; same-cycle pops earn no credit
  assign space_ok = (PW'(DEPTH) - o_count) >= PW'(MAX_PKT_FLITS);

  assign is_head   = (i_flit_type == FT_HEAD) || (i_flit_type == FT_HEAD_TAIL);
  assign is_tail   = (i_flit_type == FT_TAIL) || (i_flit_type == FT_HEAD_TAIL);
  assign last_slot = (len_q == LW'(MAX_PKT_FLITS - 1));

  // Next-state, pointer and error logic
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    err_d    = o_err;

    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (i_upstream_req && space_ok) state_d = ST_GRANT;
        if (i_flit_valid)               err_d   = 1'b1;
      end
      ST_GRANT: begin
        state_d = ST_RECV;
        len_d   = '0;
        if (i_flit_valid) err_d = 1'b1;
      end
      ST_RECV: begin
        if (i_flit_valid) begin
          len_d = len_q + LW'(1);
          if (full && !pop)                err_d = 1'b1;
          if ((len_q != '0) && is_head)    err_d = 1'b1;
          if (last_slot && !is_tail)       err_d = 1'b1;
          if (is_tail || last_slot)        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      len_q          <= '0;
      o_err          <= 1'b0;
      o_upstream_ack <= 1'b0;
      o_busy         <= 1'b0;
      o_count        <= '0;
      o_flit_valid   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      len_q          <= len_d;
      o_err          <= err_d;
      o_upstream_ack <= (state_d == ST_GRANT);
      o_busy         <= (state_d != ST_IDLE);
      o_count        <= wr_ptr_d - rd_ptr_d;
      o_flit_valid   <= (wr_ptr_d != rd_ptr_d);
    end
  end

  // Flit storage; contents are meaningless outside the pointer window
  always_ff @(posedge clk) begin
    if (push) begin
      type_mem[wr_ptr_q[AW-1:0]] <= i_flit_type;
      data_mem[wr_ptr_q[AW-1:0]] <= i_flit_data;
    end
  end

  assign o_flit_type = type_mem[rd_ptr_q[AW-1:0]];
  assign o_flit_data = data_mem[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer: queue-based packet model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_input_port_buffer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned MAXP   = 4;

  localparam logic [1:0] HEAD = 2'b00;
  localparam logic [1:0] BODY = 2'b01;
  localparam logic [1:0] TAIL = 2'b10;
  localparam logic [1:0] HT   = 2'b11;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_upstream_req = 1'b0;
  logic              o_upstream_ack;
  logic              i_flit_valid = 1'b0;
  logic [1:0]        i_flit_type = 2'b00;
  logic [DATA_W-1:0] i_flit_data = '0;
  logic              o_flit_valid;
  logic              i_flit_ready = 1'b0;
  logic [1:0]        o_flit_type;
  logic [DATA_W-1:0] o_flit_data;
  logic [$clog2(DEPTH):0] o_count;
  logic              o_busy;
  logic              o_err;

  input_port_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_PKT_FLITS(MAXP)) dut (
    .clk(clk), .reset(reset),
    .i_upstream_req(i_upstream_req), .o_upstream_ack(o_upstream_ack),
    .i_flit_valid(i_flit_valid), .i_flit_type(i_flit_type), .i_flit_data(i_flit_data),
    .o_flit_valid(o_flit_valid), .i_flit_ready(i_flit_ready),
    .o_flit_type(o_flit_type), .o_flit_data(o_flit_data),
    .o_count(o_count), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: a queue of stored flits plus the link phase
  typedef struct packed { logic [1:0] t; logic [DATA_W-1:0] d; } ent_t;
  ent_t q[$];
  int   ph = 0;        // 0 waiting for request, 1 granted, 2 receiving
  int   pkt_n = 0;
  bit   m_err = 0, m_ack = 0, m_busy = 0, started = 0;
  int   m_sz;
  bit   m_pop, m_end, m_tail;

  always @(posedge clk) begin
    if (reset) begin
      q.delete(); ph = 0; pkt_n = 0; m_err = 0; m_ack = 0; m_busy = 0; started = 1;
    end else if (started) begin
      m_sz  = q.size();
      m_pop = (m_sz != 0) && i_flit_ready;
      m_end = 0;
      if (m_pop) void'(q.pop_front());
      if (i_flit_valid) begin
        if (ph != 2) m_err = 1;
        else begin
          pkt_n++;
          if (m_sz == DEPTH && !m_pop) m_err = 1;
          else q.push_back({i_flit_type, i_flit_data});
          if (pkt_n > 1 && (i_flit_type == HEAD || i_flit_type == HT)) m_err = 1;
          m_tail = (i_flit_type == TAIL || i_flit_type == HT);
          if (m_tail || pkt_n == MAXP) m_end = 1;
          if (!m_tail && pkt_n == MAXP) m_err = 1;
        end
      end
      if (ph == 0) begin
        if (i_upstream_req && (DEPTH - m_sz) >= MAXP) ph = 1;
      end else if (ph == 1) begin
        ph = 2; pkt_n = 0;
      end else if (m_end) ph = 0;
      m_ack  = (ph == 1);
      m_busy = (ph != 0);
    end
  end

  // Every-cycle comparison against the model
  int max_cnt = 0;
  always @(negedge clk) begin
    if (started) begin
      check("ack",   64'(o_upstream_ack), 64'(m_ack));
      check("busy",  64'(o_busy),         64'(m_busy));
      check("err",   64'(o_err),          64'(m_err));
      check("count", 64'(o_count),        64'(q.size()));
      check("valid", 64'(o_flit_valid),   64'(q.size() != 0));
      if (q.size() != 0) begin
        check("head_type", 64'(o_flit_type), 64'(q[0].t));
        check("head_data", 64'(o_flit_data), 64'(q[0].d));
      end
      if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
    end
  end

  logic [DATA_W-1:0] popped[$];
  always @(posedge clk)
    if (!reset && o_flit_valid && i_flit_ready) popped.push_back(o_flit_data);

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic [DATA_W-1:0] d);
    i_flit_valid = v; i_flit_type = t; i_flit_data = d;
  endtask

  initial begin
    int n;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_ack",   64'(o_upstream_ack), 64'd0);
    check("rst_valid", 64'(o_flit_valid), 64'd0);
    check("rst_busy",  64'(o_busy), 64'd0);
    check("rst_err",   64'(o_err), 64'd0);

    // Three-flit packet into empty FIFO
    tick(); i_upstream_req = 1'b1;
    tick(); check("t1_ack", 64'(o_upstream_ack), 64'd1); i_upstream_req = 1'b0;
    tick(); check("t1_ack_one_cycle", 64'(o_upstream_ack), 64'd0); drive(1, HEAD, 32'hA0);
    tick(); drive(1, BODY, 32'hA1);
    tick(); drive(1, TAIL, 32'hA2);
    tick(); drive(0, HEAD, 0);
    check("t1_count", 64'(o_count), 64'd3);
    check("t1_busy",  64'(o_busy), 64'd0);
    check("t1_err",   64'(o_err), 64'd0);
    check("t1_data",  64'(o_flit_data), 64'hA0);
    check("t1_type",  64'(o_flit_type), 64'(HEAD));

    // Two more flits -> count 5, then request must wait for space
    i_upstream_req = 1'b1;
    tick(); check("t2_ack_a", 64'(o_upstream_ack), 64'd1); i_upstream_req = 1'b0;
    tick(); drive(1, HEAD, 32'hB0);
    tick(); drive(1, TAIL, 32'hB1);
    tick(); drive(0, HEAD, 0); i_upstream_req = 1'b1;
    check("t2_count5", 64'(o_count), 64'd5);
    tick(); check("t2_noack1", 64'(o_upstream_ack), 64'd0);
    tick(); check("t2_noack2", 64'(o_upstream_ack), 64'd0); i_flit_ready = 1'b1;
    tick(); i_flit_ready = 1'b0;
    check("t2_count4", 64'(o_count), 64'd4);
    check("t2_noack3", 64'(o_upstream_ack), 64'd0);
    check("t2_head",   64'(o_flit_data), 64'hA1);
    tick(); check("t2_ack_b", 64'(o_upstream_ack), 64'd1); i_upstream_req = 1'b0;
    tick(); drive(1, HT, 32'hB2);
    tick(); drive(0, HEAD, 0);
    check("t2_count5b", 64'(o_count), 64'd5);
    i_flit_ready = 1'b1;
    n = 0;
    while (o_count != 0 && n < 20) begin tick(); n++; end
    check("t2_drain", 64'(o_count), 64'd0);

    // Stream of single-flit packets with continuous pop
    popped.delete(); max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      i_upstream_req = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!o_upstream_ack && n < 10);
      check("t3_ack_seen", 64'(o_upstream_ack), 64'd1);
      i_upstream_req = 1'b0;
      tick(); drive(1, HT, DATA_W'(i));
      tick(); drive(0, HEAD, 0);
    end
    repeat (3) tick();
    check("t3_npop", 64'(popped.size()), 64'd20);
    for (int i = 0; i < 20 && i < popped.size(); i++)
      check("t3_order", 64'(popped[i]), 64'(i));
    check("t3_maxcnt", 64'(max_cnt), 64'd1);
    check("t3_err", 64'(o_err), 64'd0);

    // Flit in IDLE is dropped and flagged
    i_flit_ready = 1'b0;
    drive(1, HEAD, 32'hDEAD);
    tick(); drive(0, HEAD, 0);
    check("t4_err",   64'(o_err), 64'd1);
    check("t4_count", 64'(o_count), 64'd0);
    reset = 1'b1;
    tick(); reset = 1'b0;
    check("t4_err_clr", 64'(o_err), 64'd0);

    // Four flits with no tail: forced end and error
    i_upstream_req = 1'b1;
    tick(); check("t5_ack", 64'(o_upstream_ack), 64'd1); i_upstream_req = 1'b0;
    tick(); drive(1, HEAD, 32'hC0);
    tick(); drive(1, BODY, 32'hC1);
    tick(); drive(1, BODY, 32'hC2);
    tick(); check("t5_busy_mid", 64'(o_busy), 64'd1); drive(1, BODY, 32'hC3);
    tick(); drive(0, HEAD, 0);
    check("t5_busy",  64'(o_busy), 64'd0);
    check("t5_err",   64'(o_err), 64'd1);
    check("t5_count", 64'(o_count), 64'd4);
    check("t5_data",  64'(o_flit_data), 64'hC0);

    // Reset in the middle of a packet
    reset = 1'b1;
    tick(); reset = 1'b0; i_upstream_req = 1'b1;
    check("t6_clr_count", 64'(o_count), 64'd0);
    tick(); check("t6_ack", 64'(o_upstream_ack), 64'd1); i_upstream_req = 1'b0;
    tick(); drive(1, HEAD, 32'hD0);
    tick(); drive(1, BODY, 32'hD1);
    tick(); drive(0, HEAD, 0);
    check("t6_count2", 64'(o_count), 64'd2);
    check("t6_busy1",  64'(o_busy), 64'd1);
    reset = 1'b1;
    tick(); reset = 1'b0;
    check("t6_count0", 64'(o_count), 64'd0);
    check("t6_valid0", 64'(o_flit_valid), 64'd0);
    check("t6_busy0",  64'(o_busy), 64'd0);
    check("t6_err0",   64'(o_err), 64'd0);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/input_port_buffer.md
# input_port_buffer

Receive-side input buffer at the far end of a router link, directly downstream of the output-port FSM of the neighbouring router. It answers that FSM's `o_downstream_req` with a one-cycle `ack`, but only when a whole packet is guaranteed to fit. It then stores the arriving wormhole packet, flit by flit, in a circular FIFO and presents flits show-ahead to the local route-compute stage under valid/ready. Flits arrive with no per-flit backpressure, so reservation at grant time is the only overflow protection.

## Interface
- `DATA_W`, 32: flit payload width.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `MAX_PKT_FLITS`, 4: longest legal packet in flits; 1 ≤ `MAX_PKT_FLITS` ≤ `DEPTH`.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_upstream_req`  in  1  link request from upstream output unit; held high until acked.
- `o_upstream_ack`  out  1  one-cycle grant.
- `i_flit_valid`  in  1  flit present on link this cycle.
- `i_flit_type`  in  2  00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL.
- `i_flit_data`  in  `DATA_W`  flit payload.
- `o_flit_valid`  out  1  FIFO non-empty.
- `i_flit_ready`  in  1  consumer accepts head flit.
- `o_flit_type`  out  2  type of FIFO head entry.
- `o_flit_data`  out  `DATA_W`  payload of FIFO head entry.
- `o_count`  out  `$clog2(DEPTH)+1`  occupied entries.
- `o_busy`  out  1  state ≠ IDLE.
- `o_err`  out  1  sticky protocol/overflow error.

## Operation
- FSM states: IDLE, GRANT, RECV.
  - IDLE → GRANT when `i_upstream_req` && (`DEPTH` − `o_count`) ≥ `MAX_PKT_FLITS`. Otherwise stay in IDLE; the request simply waits.
  - GRANT → RECV unconditionally after one cycle. `o_upstream_ack` = 1 only in GRANT.
  - RECV → IDLE on the cycle a TAIL or HEAD_TAIL flit is accepted. Otherwise stay in RECV.
- Push: accept `i_flit_valid` only in RECV; write {type, data} at `wr_ptr`.
- Pop: `o_flit_valid` && `i_flit_ready` advances `rd_ptr`. Pop with FIFO empty is ignored.
- Pointers are `$clog2(DEPTH)+1` bits, with the MSB as the wrap bit. Empty = pointers equal; full = low bits equal and MSB differs. Increment wraps modulo 2·`DEPTH`.
- `o_count` = `wr_ptr` − `rd_ptr` (modulo arithmetic). Push and pop in the same cycle leave the count unchanged; legal even when full.
- Packet-length counter, cleared on entering RECV:
  - counts accepted flits;
  - the `MAX_PKT_FLITS`-th accepted flit is forced to end the packet (→ IDLE) even if it is not a tail, and sets `o_err`.
- Errors set `o_err`; it stays set until reset:
  - `i_flit_valid` in IDLE or GRANT: flit dropped;
  - push when full and no simultaneous pop: flit dropped, pointers unchanged;
  - HEAD or HEAD_TAIL arriving as a non-first flit of RECV: flit stored anyway.
- Types are not checked or rewritten otherwise; the first flit of a packet is stored as received.

## Timing
- Reset values: state IDLE, pointers 0, `o_count` 0, `o_upstream_ack` 0, `o_flit_valid` 0, `o_busy` 0, `o_err` 0. `o_flit_type`/`o_flit_data` are don't-care while `o_flit_valid` is 0.
- Reset asserted mid-packet returns to IDLE next edge, discards FIFO contents and clears `o_err`.
- Cycle sequence from a request:
  - req seen in IDLE at edge N;
  - ack high during cycle N+1 (GRANT);
  - earliest flit accepted at edge N+2 (RECV); upstream moves to ACTIVE on ack, so first flit arrives during cycle N+2.
- Push-to-output latency: one cycle. A flit written at edge K is visible on `o_flit_*` with `o_flit_valid` during cycle K+1.
- Outputs come from the registered pointers and memory read; no combinational path from `i_upstream_req` to `o_upstream_ack`.
- Back-to-back packets: after tail at edge T the FSM is in IDLE in cycle T+1. A held req gives a second ack in cycle T+2 if space allows.
- Free-space check uses the registered `o_count`. Pops in the same cycle are not credited.

## Test plan
- Reset, then req with FIFO empty → ack exactly one cycle, two cycles after req. Send HEAD, BODY, TAIL with `i_flit_ready`=0 → `o_count`=3, FSM IDLE, `o_err`=0.
- `DEPTH`=8, `MAX_PKT_FLITS`=4, `o_count`=5, `i_flit_ready`=0, req high → no ack. Pop 1 flit → ack in cycle 2 after `o_count` reads 4.
- Stream 20 single-flit HEAD_TAIL packets with continuous pop, data = 0..19 → output order 0..19, pointers wrap twice, `o_count` never > 1, no error.
- `i_flit_valid` high in IDLE with data 0xDEAD → `o_err`=1, `o_count` unchanged. Reset → `o_err`=0.
- Packet HEAD, BODY, BODY, BODY (no tail, `MAX_PKT_FLITS`=4) → FSM IDLE after fourth flit, `o_err`=1, 4 entries stored.
- Reset asserted while in RECV with 2 flits stored → next cycle `o_count`=0, `o_flit_valid`=0, `o_busy`=0.
